// File: rtl/bip_instr_sequencer_pkg.sv
// Shared definitions for the BIP instruction sequencer: opcodes, FSM states
// and the helper that says which instructions need a RAM read phase.
package bip_instr_sequencer_pkg;

    localparam int OPC_LEN = 5;

    localparam logic [OPC_LEN-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_LEN-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_LEN-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_LEN-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_LEN-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_LEN-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_LEN-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_LEN-1:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        MEM,
        EXEC,
        HALT
    } seqState_t;

    // LD/ADD/SUB take their operand from data RAM and need the MEM phase
    function automatic logic needsRamRead(input logic [OPC_LEN-1:0] opc);
        return (opc == OP_LD) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/bip_instr_sequencer_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear.
module bip_instr_sequencer_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // Count enabled cycles, stick at all-ones, clear on reset or restart
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bip_instr_sequencer.sv
// Fetch/sequence controller for the BIP accumulator processor. Walks the
// program counter through program memory, latches instructions and emits
// one-cycle MEM/EXEC phase strobes for Control_Block.
module bip_instr_sequencer
    import bip_instr_sequencer_pkg::*;
#(
    parameter int PC_W  = 11,
    parameter int OPC_W = 5,
    parameter int OPD_W = 11,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [PC_W-1:0]        pm_addr,
    output logic                   pm_rd,
    input  logic [OPC_W+OPD_W-1:0] pm_data,
    output logic [OPC_W-1:0]       OpCode,
    output logic [OPD_W-1:0]       Operand,
    output logic                   mem_phase,
    output logic                   exec_en,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal_op,
    output logic                   pc_overflow,
    output logic [CNT_W-1:0]       clk_count
);

    seqState_t               state;
    logic [PC_W-1:0]         pc;
    logic [OPC_W+OPD_W-1:0]  ir;
    logic [OPC_W-1:0]        decOpc;
    logic                    restart;

    assign decOpc  = pm_data[OPC_W+OPD_W-1 -: OPC_W];
    assign restart = (state == HALT) && start;

    assign pm_addr = pc;
    assign OpCode  = ir[OPC_W+OPD_W-1 -: OPC_W];
    assign Operand = ir[OPD_W-1:0];

    bip_instr_sequencer_cycle_counter #(
        .CNT_W(CNT_W)
    ) cycleCounter (
        .clk   (clk),
        .rst   (rst),
        .enable(busy),
        .clear (restart),
        .count (clk_count)
    );

    // Sequencer FSM; outputs are registered against the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            pm_rd       <= 1'b0;
            mem_phase   <= 1'b0;
            exec_en     <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            illegal_op  <= 1'b0;
            pc_overflow <= 1'b0;
        end else begin
            pm_rd     <= 1'b0;
            mem_phase <= 1'b0;
            exec_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        pm_rd <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir <= pm_data;
                    if (decOpc == OP_HLT) begin
                        state  <= HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (decOpc > OP_SUBI) begin
                        state      <= HALT;
                        busy       <= 1'b0;
                        halted     <= 1'b1;
                        illegal_op <= 1'b1;
                    end else if (needsRamRead(decOpc)) begin
                        state     <= MEM;
                        mem_phase <= 1'b1;
                    end else begin
                        state   <= EXEC;
                        exec_en <= 1'b1;
                    end
                end
                MEM: begin
                    state   <= EXEC;
                    exec_en <= 1'b1;
                end
                EXEC: begin
                    if (pc == '1) begin
                        state       <= HALT;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                        pc_overflow <= 1'b1;
                    end else begin
                        pc    <= pc + PC_W'(1);
                        state <= FETCH;
                        pm_rd <= 1'b1;
                    end
                end
                HALT: begin
                    if (start) begin
                        state       <= FETCH;
                        pc          <= '0;
                        pm_rd       <= 1'b1;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                        illegal_op  <= 1'b0;
                        pc_overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_instr_sequencer.sv
// Self-checking bench for bip_instr_sequencer: a program-memory model, a
// timing model of each run pushing expected EXEC events to a scoreboard, and
// a monitor popping them as exec_en pulses appear.
module tb_bip_instr_sequencer;

    typedef struct {
        logic [4:0]  opc;
        logic [10:0] opd;
        bit          ram;
        int          cyc;
    } expExec_t;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [10:0] pmAddr;
    logic        pmRd;
    logic [15:0] pmData;
    logic [4:0]  opCode;
    logic [10:0] operand;
    logic        memPhase, execEn, busy, halted, illegalOp, pcOverflow;
    logic [31:0] clkCount;

    logic        sRst, sStart;
    logic [1:0]  sPmAddr;
    logic        sPmRd;
    logic [15:0] sPmData;
    logic [4:0]  sOpCode;
    logic [10:0] sOperand;
    logic        sMemPhase, sExecEn, sBusy, sHalted, sIllegal, sOverflow;
    logic [31:0] sClkCount;

    logic [15:0] progMem  [0:2047];
    logic [15:0] smallMem [0:3];
    expExec_t    expQ[$];
    int          cyc = 0;
    int          nChecks = 0;
    int          nPass = 0;
    int          sExecCount = 0;
    bit          prevMem = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (pmRd)  pmData  <= progMem[pmAddr];
    always @(posedge clk) if (sPmRd) sPmData <= smallMem[sPmAddr];

    bip_instr_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pm_addr(pmAddr), .pm_rd(pmRd),
        .pm_data(pmData), .OpCode(opCode), .Operand(operand),
        .mem_phase(memPhase), .exec_en(execEn), .busy(busy), .halted(halted),
        .illegal_op(illegalOp), .pc_overflow(pcOverflow), .clk_count(clkCount)
    );

    bip_instr_sequencer #(.PC_W(2)) dutSmall (
        .clk(clk), .rst(sRst), .start(sStart), .pm_addr(sPmAddr), .pm_rd(sPmRd),
        .pm_data(sPmData), .OpCode(sOpCode), .Operand(sOperand),
        .mem_phase(sMemPhase), .exec_en(sExecEn), .busy(sBusy), .halted(sHalted),
        .illegal_op(sIllegal), .pc_overflow(sOverflow), .clk_count(sClkCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard monitor: every exec_en must match the next expected event
    always @(negedge clk) begin
        if (!rst) begin
            if (memPhase) begin
                checkVal("memExecExclusive", execEn, 0);
                if (expQ.size() > 0) checkVal("memOperand", operand, expQ[0].opd);
            end
            if (execEn) begin
                if (expQ.size() == 0) begin
                    checkVal("execUnexpected", 1, 0);
                end else begin
                    expExec_t e;
                    e = expQ.pop_front();
                    checkVal("execCycle", cyc, e.cyc);
                    checkVal("execOpCode", opCode, e.opc);
                    checkVal("execOperand", operand, e.opd);
                    checkVal("execMemBefore", prevMem, e.ram);
                end
            end
            prevMem = memPhase;
        end else begin
            prevMem = 1'b0;
        end
    end

    always @(negedge clk) if (sExecEn) sExecCount++;

    // Timing model: fetch at f, decode f+1, optional MEM, EXEC, next fetch after
    task automatic modelRun(input int t, output int haltCyc, output int lastPc, output bit ill);
        int f;
        logic [15:0] w;
        logic [4:0] opc;
        expExec_t e;
        f = t + 1;
        haltCyc = -1;
        lastPc = 0;
        ill = 1'b0;
        for (int pc = 0; pc < 2048; pc++) begin
            w = progMem[pc];
            opc = w[15:11];
            if (opc == 5'd0 || opc > 5'd7) begin
                haltCyc = f + 2;
                lastPc = pc;
                ill = (opc > 5'd7);
                break;
            end
            e.opc = opc;
            e.opd = w[10:0];
            e.ram = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
            e.cyc = f + 2 + int'(e.ram);
            expQ.push_back(e);
            f = e.cyc + 1;
        end
    endtask

    task automatic waitHalt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!halted) checkVal({tag, ".haltTimeout"}, 0, 1);
    endtask

    task automatic clearProg();
        for (int i = 0; i < 2048; i++) progMem[i] = '0;
    endtask

    task automatic runMain(input string tag);
        int t, h, lp;
        bit ill;
        logic [15:0] lastWord;
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        modelRun(t, h, lp, ill);
        lastWord = progMem[lp];
        @(negedge clk);
        start = 1'b0;
        checkVal({tag, ".pmRdFirst"}, pmRd, 1);
        checkVal({tag, ".pmAddrFirst"}, pmAddr, 0);
        waitHalt(tag);
        checkVal({tag, ".haltCycle"}, cyc, h);
        checkVal({tag, ".clkCount"}, clkCount, h - t - 1);
        checkVal({tag, ".illegalOp"}, illegalOp, ill);
        checkVal({tag, ".pcOverflow"}, pcOverflow, 0);
        checkVal({tag, ".pcFinal"}, pmAddr, lp);
        checkVal({tag, ".opCodeHeld"}, opCode, lastWord[15:11]);
        checkVal({tag, ".operandHeld"}, operand, lastWord[10:0]);
        checkVal({tag, ".busyLow"}, busy, 0);
        checkVal({tag, ".scoreboardEmpty"}, expQ.size(), 0);
    endtask

    initial begin
        int t, h1, h2, lp, n;
        bit ill;
        logic [4:0] opc;
        rst = 1'b1; sRst = 1'b1; start = 1'b0; sStart = 1'b0;
        clearProg();
        for (int i = 0; i < 4; i++) smallMem[i] = {5'b00011, 11'(i + 1)};

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst.busy", busy, 0);
        checkVal("rst.halted", halted, 0);
        checkVal("rst.pmRd", pmRd, 0);
        checkVal("rst.strobes", {memPhase, execEn}, 0);
        checkVal("rst.pmAddr", pmAddr, 0);
        checkVal("rst.ir", {opCode, operand}, 0);
        checkVal("rst.flags", {illegalOp, pcOverflow}, 0);
        checkVal("rst.clkCount", clkCount, 0);
        rst = 1'b0; sRst = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("idle.noStart", busy, 0);

        // 2: immediates then HLT
        progMem[0] = {5'b00011, 11'd5};
        progMem[1] = {5'b00101, 11'd3};
        progMem[2] = {5'b00000, 11'd0};
        runMain("immProg");

        // 3: RAM read then store
        clearProg();
        progMem[0] = {5'b00010, 11'd7};
        progMem[1] = {5'b00001, 11'd8};
        runMain("ldStoProg");

        // 4: illegal opcode at address 0
        clearProg();
        progMem[0] = {5'b01010, 11'h155};
        runMain("illegalProg");
        repeat (3) @(negedge clk);
        checkVal("illegal.opCodeHeld", opCode, 5'b01010);

        // mixed random program ending in HLT
        clearProg();
        for (int i = 0; i < 12; i++)
            progMem[i] = {5'($urandom_range(1, 7)), 11'($urandom)};
        runMain("mixedProg");

        // 6: reset during MEM of ADD
        clearProg();
        progMem[0] = {5'b00100, 11'd9};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!memPhase && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("rstMid.memSeen", memPhase, 1);
        checkVal("rstMid.memOperand", operand, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("rstMid.noExec", execEn, 0);
        checkVal("rstMid.idle", {busy, halted, memPhase}, 0);
        checkVal("rstMid.pcZero", pmAddr, 0);
        progMem[0] = {5'b00011, 11'd1};
        runMain("afterRst");

        // 5: narrow PC runs off the end of program memory
        @(negedge clk);
        sStart = 1'b1;
        t = cyc;
        @(negedge clk);
        sStart = 1'b0;
        n = 0;
        while (!sHalted && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkVal("ovf.haltCycle", cyc, t + 13);
        checkVal("ovf.execCount", sExecCount, 4);
        checkVal("ovf.flags", {sOverflow, sIllegal}, 2'b10);
        checkVal("ovf.clkCount", sClkCount, 12);
        checkVal("ovf.pmAddr", sPmAddr, 3);
        repeat (5) @(negedge clk);
        checkVal("ovf.noWrap", sPmAddr, 3);
        checkVal("ovf.stillHalted", {sHalted, sBusy}, 2'b10);
        checkVal("ovf.noMoreExec", sExecCount, 4);

        // 7: start held high through run and HALT restarts from 0
        clearProg();
        progMem[0] = {5'b00011, 11'd1};
        progMem[1] = {5'b01111, 11'd0};
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        modelRun(t, h1, lp, ill);
        modelRun(h1, h2, lp, ill);
        @(negedge clk);
        waitHalt("hold1");
        checkVal("hold.haltCycle1", cyc, h1);
        checkVal("hold.illegal1", illegalOp, 1);
        checkVal("hold.clkCount1", clkCount, h1 - t - 1);
        @(negedge clk);
        checkVal("hold.restartBusy", {busy, halted, pmRd}, 3'b101);
        checkVal("hold.flagsCleared", {illegalOp, pcOverflow}, 0);
        checkVal("hold.clkCountCleared", clkCount, 0);
        checkVal("hold.pcZero", pmAddr, 0);
        start = 1'b0;
        waitHalt("hold2");
        checkVal("hold.haltCycle2", cyc, h2);
        checkVal("hold.illegal2", illegalOp, 1);
        checkVal("hold.clkCount2", clkCount, h2 - h1 - 1);
        checkVal("hold.scoreboardEmpty", expQ.size(), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
